// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for a single shared
// combinational ALU. One operation is in flight at a time and walks through
// IDLE -> EXEC -> RESP. Operands are registered onto the ALU inputs when the
// operation is accepted. The ALU result is captured during EXEC. During RESP
// a one-cycle response pulse is registered toward the requester that owns
// the operation.

module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic [OPW-1:0]   req0_op,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_z,

    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic [OPW-1:0]   req1_op,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_z,

    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_z,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;

    // ptr_r names the favoured requester on contention (0 or 1).
    logic             ptr_r;
    logic             ptr_nxt_s;

    // gnt_r remembers which requester owns the operation in flight.
    logic             gnt_r;

    // Grant decode for the current cycle. Grants are only issued in IDLE.
    logic             sel0_s;
    logic             sel1_s;
    logic             accept_s;

    logic [WIDTH-1:0] alu_x_r;
    logic [WIDTH-1:0] alu_y_r;
    logic [OPW-1:0]   alu_op_r;
    logic [WIDTH-1:0] result_r;

    logic             rsp0_valid_r;
    logic [WIDTH-1:0] rsp0_z_r;
    logic             rsp1_valid_r;
    logic [WIDTH-1:0] rsp1_z_r;

    // Round-robin grant: the pointer breaks ties, a lone requester always wins.
    always_comb begin
        sel0_s = 1'b0;
        sel1_s = 1'b0;
        if (state_r == IDLE) begin
            if (req0_valid && req1_valid) begin
                if (ptr_r) begin
                    sel1_s = 1'b1;
                end else begin
                    sel0_s = 1'b1;
                end
            end else if (req0_valid) begin
                sel0_s = 1'b1;
            end else if (req1_valid) begin
                sel1_s = 1'b1;
            end else begin
                sel0_s = 1'b0;
                sel1_s = 1'b0;
            end
        end else begin
            sel0_s = 1'b0;
            sel1_s = 1'b0;
        end
    end

    // Ready is asserted only toward the chosen requester, so ready implies valid
    // and an asserted ready is itself the accept.
    assign req0_ready = sel0_s;
    assign req1_ready = sel1_s;
    assign accept_s   = sel0_s | sel1_s;

    // Next-state and pointer logic.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                state_nxt_s = RESP;
            end
            RESP: begin
                state_nxt_s = IDLE;
                // Favour the requester that was not just served.
                ptr_nxt_s   = ~gnt_r;
            end
            default: begin
                state_nxt_s = IDLE;
                ptr_nxt_s   = 1'b0;
            end
        endcase
    end

    // State and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ptr_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // Operand capture on accept; values then hold until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_x_r  <= {WIDTH{1'b0}};
            alu_y_r  <= {WIDTH{1'b0}};
            alu_op_r <= {OPW{1'b0}};
            gnt_r    <= 1'b0;
        end else if (accept_s) begin
            if (sel1_s) begin
                alu_x_r  <= req1_x;
                alu_y_r  <= req1_y;
                alu_op_r <= req1_op;
                gnt_r    <= 1'b1;
            end else begin
                alu_x_r  <= req0_x;
                alu_y_r  <= req0_y;
                alu_op_r <= req0_op;
                gnt_r    <= 1'b0;
            end
        end else begin
            alu_x_r  <= alu_x_r;
            alu_y_r  <= alu_y_r;
            alu_op_r <= alu_op_r;
            gnt_r    <= gnt_r;
        end
    end

    // Capture the combinational ALU result while in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r <= {WIDTH{1'b0}};
        end else if (state_r == EXEC) begin
            result_r <= alu_z;
        end else begin
            result_r <= result_r;
        end
    end

    // Requester 0 response: one-cycle pulse that leaves RESP; data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid_r <= 1'b0;
            rsp0_z_r     <= {WIDTH{1'b0}};
        end else if ((state_r == RESP) && !gnt_r) begin
            rsp0_valid_r <= 1'b1;
            rsp0_z_r     <= result_r;
        end else begin
            rsp0_valid_r <= 1'b0;
            rsp0_z_r     <= rsp0_z_r;
        end
    end

    // Requester 1 response: one-cycle pulse that leaves RESP; data holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid_r <= 1'b0;
            rsp1_z_r     <= {WIDTH{1'b0}};
        end else if ((state_r == RESP) && gnt_r) begin
            rsp1_valid_r <= 1'b1;
            rsp1_z_r     <= result_r;
        end else begin
            rsp1_valid_r <= 1'b0;
            rsp1_z_r     <= rsp1_z_r;
        end
    end

    assign alu_x      = alu_x_r;
    assign alu_y      = alu_y_r;
    assign alu_op     = alu_op_r;
    assign rsp0_valid = rsp0_valid_r;
    assign rsp0_z     = rsp0_z_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp1_z     = rsp1_z_r;
    assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a small external ALU
// (op 0 = add, op 1 = and).

module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_x, req0_y, req1_x, req1_y;
    logic [2:0]  req0_op, req1_op;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_z, rsp1_z;
    logic [15:0] alu_x, alu_y, alu_z;
    logic [2:0]  alu_op;
    logic        busy;

    int total;
    int bad;
    int cnt0;
    int cnt1;

    alu_arbiter #(.WIDTH(16), .OPW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_op(req0_op),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_z(rsp0_z),
        .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_op(req1_op),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_z(rsp1_z),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_z(alu_z),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shared ALU.
    always_comb begin
        case (alu_op)
            3'd0:    alu_z = alu_x + alu_y;
            3'd1:    alu_z = alu_x & alu_y;
            default: alu_z = 16'h0000;
        endcase
    end

    // Count response pulses.
    always @(posedge clk) begin
        if (rsp0_valid) cnt0 <= cnt0 + 1;
        if (rsp1_valid) cnt1 <= cnt1 + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        repeat (2) step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        total++; if (alu_x !== 16'h0000 || alu_y !== 16'h0000 || alu_op !== 3'd0) begin bad++; $display("FAIL reset_alu got=%0h/%0h/%0h exp=0/0/0", alu_x, alu_y, alu_op); end
        total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp0_z !== 16'h0000 || rsp1_z !== 16'h0000) begin bad++; $display("FAIL reset_rsp got=%0h %0h %0h %0h exp=0 0 0 0", rsp0_valid, rsp1_valid, rsp0_z, rsp1_z); end
        do_reset();
    endtask

    task automatic test_single_add();
        int c1;
        c1 = cnt1;
        req0_x = 16'h0005; req0_y = 16'h0003; req0_op = 3'd0; req0_valid = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL single_ready got=%0h%0h exp=10", req0_ready, req1_ready); end
        step();
        req0_valid = 1'b0;
        total++; if (busy !== 1'b1 || alu_x !== 16'h0005 || alu_y !== 16'h0003) begin bad++; $display("FAIL single_exec got=%0h %0h %0h exp=1 5 3", busy, alu_x, alu_y); end
        step();
        total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL single_early_rsp got=%0h exp=0", rsp0_valid); end
        step();
        total++; if (rsp0_valid !== 1'b1 || rsp0_z !== 16'h0008) begin bad++; $display("FAIL single_rsp got=%0h %0h exp=1 8", rsp0_valid, rsp0_z); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%0h exp=0", busy); end
        step();
        total++; if (rsp0_valid !== 1'b0 || rsp0_z !== 16'h0008) begin bad++; $display("FAIL single_hold got=%0h %0h exp=0 8", rsp0_valid, rsp0_z); end
        total++; if (cnt1 != c1) begin bad++; $display("FAIL single_no_rsp1 got=%0d exp=%0d", cnt1, c1); end
    endtask

    task automatic test_contention();
        do_reset();
        req0_x = 16'h00F0; req0_y = 16'h0F0F; req0_op = 3'd1; req0_valid = 1'b1;
        req1_x = 16'h0001; req1_y = 16'h0002; req1_op = 3'd0; req1_valid = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL cont_first got=%0h%0h exp=10", req0_ready, req1_ready); end
        step();
        req0_valid = 1'b0;
        #1;
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL cont_exec_ready got=%0h exp=0", req1_ready); end
        step();
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL cont_resp_ready got=%0h exp=0", req1_ready); end
        step();
        total++; if (rsp0_valid !== 1'b1 || rsp0_z !== 16'h0000) begin bad++; $display("FAIL cont_rsp0 got=%0h %0h exp=1 0", rsp0_valid, rsp0_z); end
        total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL cont_second_ready got=%0h exp=1", req1_ready); end
        step();
        req1_valid = 1'b0;
        total++; if (alu_x !== 16'h0001 || alu_op !== 3'd0) begin bad++; $display("FAIL cont_alu got=%0h %0h exp=1 0", alu_x, alu_op); end
        step();
        step();
        total++; if (rsp1_valid !== 1'b1 || rsp1_z !== 16'h0003 || rsp0_valid !== 1'b0) begin bad++; $display("FAIL cont_rsp1 got=%0h %0h %0h exp=1 3 0", rsp1_valid, rsp1_z, rsp0_valid); end
    endtask

    task automatic test_alternate();
        int grants[$];
        int gcyc[$];
        int c0, c1;
        c0 = cnt0; c1 = cnt1;
        req0_x = 16'h0003; req0_y = 16'h0004; req0_op = 3'd0; req0_valid = 1'b1;
        req1_x = 16'hFF00; req1_y = 16'h0FF0; req1_op = 3'd1; req1_valid = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            total++; if (req0_ready === 1'b1 && req1_ready === 1'b1) begin bad++; $display("FAIL alt_two_ready cycle=%0d got=11 exp=one", c); end
            if (req0_ready === 1'b1) begin grants.push_back(0); gcyc.push_back(c); end
            if (req1_ready === 1'b1) begin grants.push_back(1); gcyc.push_back(c); end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++; if (grants.size() != 4) begin bad++; $display("FAIL alt_count got=%0d exp=4", grants.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) begin
                total++; if (grants[i] != (i % 2) || gcyc[i] != 3 * i) begin bad++; $display("FAIL alt_grant%0d got=req%0d@%0d exp=req%0d@%0d", i, grants[i], gcyc[i], i % 2, 3 * i); end
            end
        end
        total++; if (cnt0 - c0 != 2 || cnt1 - c1 != 2) begin bad++; $display("FAIL alt_pulses got=%0d/%0d exp=2/2", cnt0 - c0, cnt1 - c1); end
        total++; if (rsp0_z !== 16'h0007 || rsp1_z !== 16'h0F00) begin bad++; $display("FAIL alt_data got=%0h %0h exp=7 f00", rsp0_z, rsp1_z); end
    endtask

    task automatic test_wrap();
        req0_x = 16'hFFFF; req0_y = 16'h0001; req0_op = 3'd0; req0_valid = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready got=%0h exp=1", req0_ready); end
        step();
        req0_valid = 1'b0;
        step();
        step();
        total++; if (rsp0_valid !== 1'b1 || rsp0_z !== 16'h0000) begin bad++; $display("FAIL wrap_rsp got=%0h %0h exp=1 0", rsp0_valid, rsp0_z); end
    endtask

    task automatic test_reset_abort();
        int c1;
        step();
        req1_x = 16'h1234; req1_y = 16'h0001; req1_op = 3'd0; req1_valid = 1'b1;
        #1;
        total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%0h exp=1", req1_ready); end
        step();
        req1_valid = 1'b0;
        total++; if (busy !== 1'b1 || alu_x !== 16'h1234) begin bad++; $display("FAIL abort_exec got=%0h %0h exp=1 1234", busy, alu_x); end
        c1 = cnt1;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || alu_x !== 16'h0000 || alu_y !== 16'h0000 || rsp1_z !== 16'h0000) begin bad++; $display("FAIL abort_zero got=%0h %0h %0h %0h exp=0 0 0 0", busy, alu_x, alu_y, rsp1_z); end
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        total++; if (cnt1 != c1 || rsp1_z !== 16'h0000) begin bad++; $display("FAIL abort_no_rsp got=%0d %0h exp=%0d 0", cnt1, rsp1_z, c1); end
        req0_x = 16'h0001; req0_y = 16'h0001; req0_op = 3'd0; req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL abort_next_grant got=%0h%0h exp=10", req0_ready, req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_late_valid();
        do_reset();
        req0_x = 16'h0011; req0_y = 16'h0022; req0_op = 3'd0; req0_valid = 1'b1;
        #1;
        step();
        req0_valid = 1'b0;
        req1_x = 16'h0007; req1_y = 16'h0008; req1_op = 3'd0; req1_valid = 1'b1;
        #1;
        total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL late_exec_ready got=%0h exp=0", req1_ready); end
        step();
        total++; if (req1_ready !== 1'b0 || alu_x !== 16'h0011) begin bad++; $display("FAIL late_resp got=%0h %0h exp=0 11", req1_ready, alu_x); end
        step();
        total++; if (req1_ready !== 1'b1 || rsp0_valid !== 1'b1 || rsp0_z !== 16'h0033 || alu_x !== 16'h0011) begin bad++; $display("FAIL late_idle got=%0h %0h %0h %0h exp=1 1 33 11", req1_ready, rsp0_valid, rsp0_z, alu_x); end
        step();
        req1_valid = 1'b0;
        total++; if (alu_x !== 16'h0007) begin bad++; $display("FAIL late_alu got=%0h exp=7", alu_x); end
        step();
        step();
        total++; if (rsp1_valid !== 1'b1 || rsp1_z !== 16'h000F) begin bad++; $display("FAIL late_rsp1 got=%0h %0h exp=1 f", rsp1_valid, rsp1_z); end
    endtask

    initial begin
        total = 0; bad = 0; cnt0 = 0; cnt1 = 0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_x = 16'h0000; req0_y = 16'h0000; req0_op = 3'd0;
        req1_valid = 1'b0; req1_x = 16'h0000; req1_y = 16'h0000; req1_op = 3'd0;
        test_reset();
        test_single_add();
        test_contention();
        test_alternate();
        test_wrap();
        test_reset_abort();
        test_late_valid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, data word width; SHALL match the codebase `WORD width.
REQ-002 Parameter OPW, default 3, ALU opcode width.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_x, req0_y  input  WIDTH each  requester 0 operands.
REQ-007 req0_op  input  OPW  requester 0 ALU opcode.
REQ-008 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-009 rsp0_valid  output  1  one-cycle pulse; rsp0_z valid.
REQ-010 rsp0_z  output  WIDTH  requester 0 result.
REQ-011 req1_valid, req1_x, req1_y, req1_op, req1_ready, rsp1_valid, rsp1_z: same directions, widths and meanings for requester 1.
REQ-012 alu_x, alu_y  output  WIDTH  registered operands to the shared combinational ALU.
REQ-013 alu_op  output  OPW  registered opcode to the ALU.
REQ-014 alu_z  input  WIDTH  ALU result.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, EXEC and RESP.
REQ-017 IDLE: if any reqN_valid, the block SHALL grant exactly one requester and return to IDLE only via EXEC and RESP.
REQ-018 Arbitration SHALL be round-robin: a 1-bit priority pointer names the favoured requester; on contention the pointer's requester wins; with a single valid, that requester wins regardless of pointer.
REQ-019 reqN_ready SHALL be combinational, high only in IDLE for the granted requester; at most one ready high per cycle.
REQ-020 Accept = reqN_valid && reqN_ready; on accept, x/y/op SHALL be registered onto alu_x/alu_y/alu_op and state SHALL go to EXEC.
REQ-021 EXEC (one cycle): alu_z SHALL be registered into the result register; state goes to RESP.
REQ-022 RESP (one cycle): rspN_valid SHALL be high for the granted requester only, with rspN_z = captured result; pointer SHALL move to the other requester; state goes to IDLE.
REQ-023 Latency: accept at edge E; rspN_valid high from edge E+2 to edge E+3; throughput one op per 3 cycles.
REQ-024 rspN_z SHALL hold its last value when rspN_valid is low; the non-granted rsp port SHALL not change.
REQ-025 alu_x/alu_y/alu_op SHALL hold stable from accept through RESP.
REQ-026 Requesters SHALL hold valid and operands stable until ready; valid dropped before accept SHALL cause no grant.
REQ-027 A new valid arriving during EXEC/RESP SHALL wait; no ready outside IDLE.
REQ-028 Result width SHALL be WIDTH; no carry/overflow outputs.

Reset
REQ-029 On rst_n low, immediately: state IDLE, pointer 0, alu_x/alu_y/alu_op 0, result and rsp0_z/rsp1_z 0, rsp valids 0, busy 0.
REQ-030 Reset during EXEC or RESP SHALL abort the operation; no rspN_valid SHALL be produced for it.
REQ-031 First grant after reset with both valid SHALL go to requester 0.

Verification (bench ALU model: alu_z = alu_x + alu_y for op 0, alu_x & alu_y for op 1)
REQ-032 After reset, req0 x=0x0005 y=0x0003 op=0 -> req0_ready same cycle, rsp0_valid 2 edges later, rsp0_z=0x0008, rsp1_valid never high.
REQ-033 Both valid after reset, req0 (0x00F0,0x0F0F,op1), req1 (0x0001,0x0002,op0) -> req0 served first (rsp0_z=0x0000), then req1 (rsp1_z=0x0003); ready pulses 3 cycles apart.
REQ-034 Both held valid for 4 ops -> grants alternate 0,1,0,1; never two readys in one cycle.
REQ-035 req0 x=0xFFFF y=0x0001 op0 -> rsp0_z=0x0000 (wrap, no carry).
REQ-036 rst_n low during EXEC of req1 op -> outputs zero immediately, no rsp1_valid; next contended grant goes to requester 0.
REQ-037 req1_valid rises during EXEC of req0 -> req1_ready only in the cycle after RESP; alu_x unchanged through req0 RESP.
